// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encoding and address helper for the FP16 ROM streamer.
package dmem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 512;

    localparam logic [DATA_W-1:0] FP16_NEG_ZERO = 16'h8000;

    // Sequencer states. Kept as plain constants so older tools and checkers can match raw codes.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Next ROM address, wrapping DEPTH-1 back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dmem_fp16_streamer_if.sv
// Command, ROM and output-stream signals of the FP16 ROM streamer, grouped as one bus.
//
// Stream handshake: a word transfers on every rising clk edge where m_valid and m_ready
// are both high. Once m_valid is raised it stays high, and m_data/m_last stay unchanged,
// until that transfer happens. m_ready may change freely and is not required before
// m_valid is raised. m_last marks the final word of a command.
interface dmem_fp16_streamer_if;
    import dmem_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    state_t            state;

    // Streamer side.
    modport master (
        input  start, base_addr, len, rom_q, m_ready,
        output busy, done, rom_addr, m_data, m_valid, m_last, state
    );

    // Controller / ROM / consumer side.
    modport slave (
        output start, base_addr, len, rom_q, m_ready,
        input  busy, done, rom_addr, m_data, m_valid, m_last, state
    );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO used as the streamer's output skid buffer; head is visible combinationally.
module stream_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    assign empty    = (cnt == 2'd0);
    assign full     = (cnt == 2'd2);
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dmem_fp16_streamer.sv
// Walks len consecutive ROM addresses from base_addr and streams each FP16 word with a last marker.
module dmem_fp16_streamer
    import dmem_pkg::*;
#(
    parameter bit CANON_NZ = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    dmem_fp16_streamer_if.master bus
);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   fetch_rem;
    logic              fetch;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   head;
    logic [DATA_W-1:0] word;
    logic              last_word;

    assign pop       = ~fifo_empty & bus.m_ready;
    // Fetch only while words remain and the buffer has (or is about to have) a free slot.
    assign fetch     = (state_r == S_RUN) && (fetch_rem != '0) && (!fifo_full || pop);
    assign word      = (CANON_NZ && (bus.rom_q == FP16_NEG_ZERO)) ? '0 : bus.rom_q;
    assign last_word = (fetch_rem == (ADDR_W+1)'(1));

    stream_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .push_data ({word, last_word}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Command FSM plus the address and remaining-fetch counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            addr_r    <= '0;
            fetch_rem <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r   <= S_RUN;
                        addr_r    <= bus.base_addr;
                        fetch_rem <= bus.len;
                    end
                end
                S_RUN: begin
                    if (fetch) begin
                        addr_r    <= wrap_inc(addr_r);
                        fetch_rem <= fetch_rem - (ADDR_W+1)'(1);
                    end
                    // Finish on handing over the last word; a zero-length command has nothing
                    // to fetch or drain, so it finishes after one RUN cycle and keeps the
                    // same start-to-done spacing as a one-word command minus the word.
                    if ((pop && head[0]) || ((fetch_rem == '0) && fifo_empty)) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = addr_r;
    assign bus.m_valid  = ~fifo_empty;
    assign bus.m_data   = head[DATA_W:1];
    assign bus.m_last   = head[0] & ~fifo_empty;
    assign bus.busy     = (state_r == S_RUN);
    assign bus.done     = (state_r == S_DONE);
    assign bus.state    = state_r;

endmodule

// File: tb/tb_dmem_fp16_streamer.sv
// Self-checking bench for dmem_fp16_streamer with an array ROM model and a queue reference.
module tb_dmem_fp16_streamer;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [DATA_W-1:0] rom [DEPTH];

    dmem_fp16_streamer_if bus0 ();
    dmem_fp16_streamer_if bus1 ();

    assign bus0.rom_q = rom[bus0.rom_addr];
    assign bus1.rom_q = rom[bus1.rom_addr];

    dmem_fp16_streamer #(.CANON_NZ(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dmem_fp16_streamer #(.CANON_NZ(1'b1)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W-1:0] got_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one command on bus0 and score every accepted word against the ROM model.
    task automatic run_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n,
                           input bit rand_ready, input bit timed, input bit poke);
        int                cyc;
        int                budget;
        bit                done_seen;
        bit                pv;
        bit                pr;
        logic [DATA_W-1:0] pd;
        logic              pl;
        logic              rdy;
        logic [DATA_W:0]   e;

        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({rom[(int'(base) + i) % DEPTH], i == int'(n) - 1});
        end

        @(negedge clk);
        bus0.start     = 1'b1;
        bus0.base_addr = base;
        bus0.len       = n;
        bus0.m_ready   = 1'b1;
        cyc       = 0;
        done_seen = 1'b0;
        pv        = 1'b0;
        pr        = 1'b0;
        pd        = '0;
        pl        = 1'b0;
        budget    = 4 * int'(n) + 20;

        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus0.start = 1'b0;
            if (poke && cyc == 3) begin
                bus0.start     = 1'b1;
                bus0.base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                bus0.len       = (ADDR_W+1)'($urandom_range(1, DEPTH));
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus0.m_ready = rdy;

            if (timed && cyc == 1) check("busy_rise", 32'(bus0.busy), 32'(1));
            if (pv && !pr) begin
                check("stall_valid", 32'(bus0.m_valid), 32'(1));
                check("stall_data", 32'(bus0.m_data), 32'(pd));
                check("stall_last", 32'(bus0.m_last), 32'(pl));
            end
            if (bus0.m_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(bus0.m_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(bus0.m_data), 32'(e[DATA_W:1]));
                    check("last", 32'(bus0.m_last), 32'(e[0]));
                    if (timed) check("word_cycle", 32'(cyc), 32'(2 + got_q.size()));
                    got_q.push_back(bus0.m_data);
                end
            end
            pv = bus0.m_valid;
            pr = rdy;
            pd = bus0.m_data;
            pl = bus0.m_last;
            if (bus0.done) begin
                done_seen = 1'b1;
                check("done_q_empty", 32'(exp_q.size()), 32'(0));
                check("done_busy", 32'(bus0.busy), 32'(0));
                if (timed) check("done_cycle", 32'(cyc), 32'(int'(n) + 2));
            end
        end
        if (!done_seen) check("done_timeout", 32'(bus0.done), 32'(1));
        bus0.start   = 1'b0;
        bus0.m_ready = 1'b1;
        @(negedge clk);
        check("done_pulse", 32'(bus0.done), 32'(0));
        check("idle_state", 32'(bus0.state), 32'(S_IDLE));
    endtask

    initial begin
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W:0]   rl;

        for (int i = 0; i < DEPTH; i++) rom[i] = 16'($urandom_range(0, 65535));
        rom[0]   = 16'h4601;
        rom[1]   = 16'h38B4;
        rom[2]   = 16'h3C9D;
        rom[4]   = 16'h8000;
        rom[510] = 16'h30D2;
        rom[511] = 16'hB8B4;

        rst_n          = 1'b0;
        bus0.start     = 1'b0;
        bus0.base_addr = '0;
        bus0.len       = '0;
        bus0.m_ready   = 1'b0;
        bus1.start     = 1'b0;
        bus1.base_addr = '0;
        bus1.len       = '0;
        bus1.m_ready   = 1'b1;

        // Reset values.
        #12;
        check("rst_busy", 32'(bus0.busy), 32'(0));
        check("rst_done", 32'(bus0.done), 32'(0));
        check("rst_rom_addr", 32'(bus0.rom_addr), 32'(0));
        check("rst_valid", 32'(bus0.m_valid), 32'(0));
        check("rst_last", 32'(bus0.m_last), 32'(0));
        check("rst_data", 32'(bus0.m_data), 32'(0));
        check("rst_state", 32'(bus0.state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Short burst from address 0 at full rate.
        run_cmd(9'd0, 10'd3, 1'b0, 1'b1, 1'b0);
        check("b0_count", 32'(got_q.size()), 32'(3));
        check("b0_w0", 32'(got_q[0]), 32'(16'h4601));
        check("b0_w1", 32'(got_q[1]), 32'(16'h38B4));
        check("b0_w2", 32'(got_q[2]), 32'(16'h3C9D));

        // Address wrap 511 -> 0.
        run_cmd(9'd510, 10'd4, 1'b0, 1'b1, 1'b0);
        check("wr_w0", 32'(got_q[0]), 32'(16'h30D2));
        check("wr_w1", 32'(got_q[1]), 32'(16'hB8B4));
        check("wr_w2", 32'(got_q[2]), 32'(16'h4601));
        check("wr_w3", 32'(got_q[3]), 32'(16'h38B4));
        check("wr_rom_addr", 32'(bus0.rom_addr), 32'((510 + 4) % DEPTH));

        // Negative zero passes through unchanged without canonicalisation.
        run_cmd(9'd4, 10'd1, 1'b0, 1'b1, 1'b0);
        check("nz_raw", 32'(got_q[0]), 32'(16'h8000));

        // Canonicalising instance turns -0.0 into +0.0.
        @(negedge clk);
        bus1.start     = 1'b1;
        bus1.base_addr = 9'd4;
        bus1.len       = 10'd1;
        @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        check("nz_canon_valid", 32'(bus1.m_valid), 32'(1));
        check("nz_canon_data", 32'(bus1.m_data), 32'(16'h0000));
        check("nz_canon_last", 32'(bus1.m_last), 32'(1));
        @(negedge clk);
        check("nz_canon_done", 32'(bus1.done), 32'(1));

        // Random backpressure.
        run_cmd(9'd0, 10'd20, 1'b1, 1'b0, 1'b0);
        check("bp_count", 32'(got_q.size()), 32'(20));

        // Zero-length command.
        run_cmd(9'd0, 10'd0, 1'b0, 1'b1, 1'b0);
        check("z_count", 32'(got_q.size()), 32'(0));

        // Start while busy is ignored.
        run_cmd(9'd37, 10'd12, 1'b0, 1'b1, 1'b1);
        check("poke_count", 32'(got_q.size()), 32'(12));

        // Full sweep of every ROM word.
        run_cmd(9'd100, 10'd512, 1'b1, 1'b0, 1'b0);
        check("full_count", 32'(got_q.size()), 32'(DEPTH));
        check("full_rom_addr", 32'(bus0.rom_addr), 32'(100));

        // Random commands.
        for (int k = 0; k < 4; k++) begin
            rb = ADDR_W'($urandom_range(0, DEPTH - 1));
            rl = (ADDR_W+1)'($urandom_range(1, 40));
            run_cmd(rb, rl, 1'b1, 1'b0, rl >= 10'd4);
            check("rand_count", 32'(got_q.size()), 32'(rl));
        end

        // Asynchronous reset in the middle of a command.
        @(negedge clk);
        bus0.start     = 1'b1;
        bus0.base_addr = 9'd0;
        bus0.len       = 10'd20;
        bus0.m_ready   = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check("pre_rst_data", 32'(bus0.m_data), 32'(rom[c - 2]));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus0.busy), 32'(0));
        check("mid_rst_done", 32'(bus0.done), 32'(0));
        check("mid_rst_rom_addr", 32'(bus0.rom_addr), 32'(0));
        check("mid_rst_valid", 32'(bus0.m_valid), 32'(0));
        check("mid_rst_last", 32'(bus0.m_last), 32'(0));
        check("mid_rst_data", 32'(bus0.m_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(9'd0, 10'd20, 1'b0, 1'b1, 1'b0);
        check("replay_w0", 32'(got_q[0]), 32'(16'h4601));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
